// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes and the
// classification of long-latency operations.
package mult_div_unit_pkg;

    localparam int unsigned OpW = 4;

    typedef enum logic [OpW-1:0] {
        MdNone  = 4'd0,
        MdMult  = 4'd1,
        MdMultu = 4'd2,
        MdDiv   = 4'd3,
        MdDivu  = 4'd4,
        MdMfhi  = 4'd5,
        MdMflo  = 4'd6,
        MdMthi  = 4'd7,
        MdMtlo  = 4'd8
    } md_op_e;

    // True for operations that occupy the unit for several cycles.
    function automatic logic is_md_long(input logic [OpW-1:0] op);
        return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the E-stage controller and the multiply/divide unit.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic           md_start;
    logic [OpW-1:0] md_op;
    logic [31:0]    src_a;
    logic [31:0]    src_b;
    logic           md_use_D;
    logic           busy;
    logic           stall_md;
    logic [31:0]    md_rdata;
    logic [31:0]    hi_o;
    logic [31:0]    lo_o;

    modport master (
        output md_start, md_op, src_a, src_b, md_use_D,
        input  busy, stall_md, md_rdata, hi_o, lo_o
    );

    modport slave (
        input  md_start, md_op, src_a, src_b, md_use_D,
        output busy, stall_md, md_rdata, hi_o, lo_o
    );

endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit owning HI/LO. The result is computed at issue and held in pending
// registers; a down-counter models the fixed latency before it is committed to HI/LO.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [CntW-1:0] count_q;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     pend_hi_q, pend_lo_q;
    logic            pend_wr_q;

    logic            busy;
    logic            is_long;
    logic [CntW-1:0] start_cnt;
    logic [31:0]     res_hi, res_lo;
    logic            res_wr;
    logic [63:0]     prod;
    logic [31:0]     div_b;

    assign busy    = (count_q != '0);
    assign is_long = is_md_long(md.md_op);

    always_comb begin
        prod      = '0;
        res_hi    = '0;
        res_lo    = '0;
        res_wr    = 1'b1;
        start_cnt = CntW'(DIV_LAT);
        // Substitute divisor 1 so a zero divisor never produces X; the write is suppressed.
        div_b     = (md.src_b == '0) ? 32'd1 : md.src_b;
        case (md.md_op)
            MdMult: begin
                prod = $signed({{32{md.src_a[31]}}, md.src_a})
                     * $signed({{32{md.src_b[31]}}, md.src_b});
                {res_hi, res_lo} = prod;
                start_cnt        = CntW'(MULT_LAT);
            end
            MdMultu: begin
                prod             = {32'd0, md.src_a} * {32'd0, md.src_b};
                {res_hi, res_lo} = prod;
                start_cnt        = CntW'(MULT_LAT);
            end
            MdDiv: begin
                res_wr = (md.src_b != '0);
                if (md.src_a == 32'h8000_0000 && md.src_b == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = '0;
                end else begin
                    res_lo = $signed(md.src_a) / $signed(div_b);
                    res_hi = $signed(md.src_a) % $signed(div_b);
                end
            end
            MdDivu: begin
                res_wr = (md.src_b != '0);
                res_lo = md.src_a / div_b;
                res_hi = md.src_a % div_b;
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else if (busy) begin
            // Starts arriving while busy are ignored.
            count_q <= count_q - CntW'(1);
            if (count_q == CntW'(1) && pend_wr_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end
        end else if (md.md_start) begin
            if (is_long) begin
                count_q   <= start_cnt;
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_wr_q <= res_wr;
            end else if (md.md_op == MdMthi) begin
                hi_q <= md.src_a;
            end else if (md.md_op == MdMtlo) begin
                lo_q <= md.src_a;
            end
        end
    end

    always_comb begin
        md.md_rdata = '0;
        if (md.md_op == MdMfhi) begin
            md.md_rdata = hi_q;
        end else if (md.md_op == MdMflo) begin
            md.md_rdata = lo_q;
        end
    end

    assign md.busy     = busy;
    assign md.stall_md = md.md_use_D && (busy || (md.md_start && is_long));
    assign md.hi_o     = hi_q;
    assign md.lo_o     = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int unsigned MultLat = 5;
    localparam int unsigned DivLat  = 10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   proto_err;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mult_div_unit_if mif ();

    mult_div_unit #(
        .MULT_LAT(MultLat),
        .DIV_LAT (DivLat)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starting an op while busy never happens in this bench; flag it if it does.
    always @(posedge clk) begin
        if (!reset && mif.md_start && mif.busy) begin
            proto_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mif.md_start = 1'b0;
        mif.md_op    = MdNone;
        mif.src_a    = '0;
        mif.src_b    = '0;
        mif.md_use_D = 1'b0;
    endtask

    // Reference result of a long op: plain integer arithmetic on 64-bit values.
    function automatic void model_long(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic wr,
                                       output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, q, r;
        longint unsigned p;
        wr = 1'b1;
        h  = hi_m;
        l  = lo_m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MdMult:  begin q = sa * sb; {h, l} = q[63:0]; end
            MdMultu: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p[63:0]; end
            MdDiv: begin
                if (b == 0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            MdDivu: begin
                if (b == 0) wr = 1'b0;
                else begin l = a / b; h = a % b; end
            end
            default: wr = 1'b0;
        endcase
    endfunction

    // Issue one long op and follow it cycle by cycle until the result lands.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic use_d, input string name);
        logic        wr;
        logic [31:0] eh, el;
        int unsigned lat;
        lat = (op == MdMult || op == MdMultu) ? MultLat : DivLat;
        model_long(op, a, b, wr, eh, el);
        mif.md_start = 1'b1;
        mif.md_op    = op;
        mif.src_a    = a;
        mif.src_b    = b;
        mif.md_use_D = use_d;
        #1;
        checks++;
        if (mif.stall_md !== use_d) begin
            failures++;
            $display("FAIL %s start_stall got=%b want=%b", name, mif.stall_md, use_d);
        end
        tick();
        mif.md_start = 1'b0;
        mif.md_op    = MdNone;
        for (int k = 0; k < int'(lat); k++) begin
            checks++;
            if (mif.busy !== 1'b1 || mif.stall_md !== use_d || mif.hi_o !== hi_m
                || mif.lo_o !== lo_m) begin
                failures++;
                $display("FAIL %s inflight k=%0d busy=%b stall=%b hi=%h lo=%h want hi=%h lo=%h",
                         name, k, mif.busy, mif.stall_md, mif.hi_o, mif.lo_o, hi_m, lo_m);
            end
            tick();
        end
        if (wr) begin
            hi_m = eh;
            lo_m = el;
        end
        checks++;
        if (mif.busy !== 1'b0 || mif.hi_o !== hi_m || mif.lo_o !== lo_m) begin
            failures++;
            $display("FAIL %s result busy=%b hi=%h lo=%h want hi=%h lo=%h",
                     name, mif.busy, mif.hi_o, mif.lo_o, hi_m, lo_m);
        end
        mif.md_use_D = 1'b0;
    endtask

    task automatic short_op(input logic [3:0] op, input logic [31:0] a, input string name);
        logic [31:0] want_rd;
        mif.md_start = 1'b1;
        mif.md_op    = op;
        mif.src_a    = a;
        mif.md_use_D = 1'b1;
        want_rd      = (op == MdMfhi) ? hi_m : (op == MdMflo) ? lo_m : 32'd0;
        #1;
        checks++;
        if (mif.md_rdata !== want_rd || mif.stall_md !== 1'b0) begin
            failures++;
            $display("FAIL %s rdata=%h stall=%b want rdata=%h stall=0",
                     name, mif.md_rdata, mif.stall_md, want_rd);
        end
        tick();
        if (op == MdMthi) hi_m = a;
        if (op == MdMtlo) lo_m = a;
        idle_inputs();
        checks++;
        if (mif.busy !== 1'b0 || mif.hi_o !== hi_m || mif.lo_o !== lo_m) begin
            failures++;
            $display("FAIL %s after busy=%b hi=%h lo=%h want hi=%h lo=%h",
                     name, mif.busy, mif.hi_o, mif.lo_o, hi_m, lo_m);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        checks++;
        if (mif.hi_o !== 0 || mif.lo_o !== 0 || mif.busy !== 0 || mif.stall_md !== 0
            || mif.md_rdata !== 0) begin
            failures++;
            $display("FAIL reset hi=%h lo=%h busy=%b stall=%b rdata=%h want all zero",
                     mif.hi_o, mif.lo_o, mif.busy, mif.stall_md, mif.md_rdata);
        end
    endtask

    task automatic test_mult();
        run_long(MdMult, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_neg");
        checks++;
        if (mif.hi_o !== 32'hFFFF_FFFF || mif.lo_o !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL mult_const hi=%h lo=%h want FFFFFFFF FFFFFFFE", mif.hi_o, mif.lo_o);
        end
        run_long(MdMultu, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        checks++;
        if (mif.hi_o !== 32'h0000_0001 || mif.lo_o !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_const hi=%h lo=%h want 00000001 FFFFFFFE", mif.hi_o, mif.lo_o);
        end
    endtask

    task automatic test_div();
        run_long(MdDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        checks++;
        if (mif.hi_o !== 32'hFFFF_FFFF || mif.lo_o !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_const hi=%h lo=%h want FFFFFFFF FFFFFFFD", mif.hi_o, mif.lo_o);
        end
        run_long(MdDivu, 32'd7, 32'd0, 1'b0, "divu_zero");
        run_long(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        checks++;
        if (mif.hi_o !== 32'h0 || mif.lo_o !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_ovf_const hi=%h lo=%h want 00000000 80000000", mif.hi_o, mif.lo_o);
        end
        short_op(MdMfhi, 32'd0, "mfhi");
    endtask

    task automatic test_stall();
        run_long(MdMult, 32'd1234, 32'd5678, 1'b1, "mult_stall");
        short_op(MdMflo, 32'd0, "mflo_after_mult");
        short_op(MdMthi, 32'h1234, "mthi");
        checks++;
        if (mif.hi_o !== 32'h1234) begin
            failures++;
            $display("FAIL mthi_const hi=%h want 00001234", mif.hi_o);
        end
        short_op(MdMtlo, 32'hCAFE_F00D, "mtlo");
    endtask

    task automatic test_reset_mid();
        short_op(MdMthi, 32'hDEAD_BEEF, "pre_abort_mthi");
        mif.md_start = 1'b1;
        mif.md_op    = MdDiv;
        mif.src_a    = 32'd1000;
        mif.src_b    = 32'd7;
        tick();
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        checks++;
        if (mif.hi_o !== 0 || mif.lo_o !== 0 || mif.busy !== 0) begin
            failures++;
            $display("FAIL abort hi=%h lo=%h busy=%b want 0 0 0", mif.hi_o, mif.lo_o, mif.busy);
        end
        for (int i = 0; i < int'(DivLat) + 2; i++) tick();
        checks++;
        if (mif.hi_o !== 0 || mif.lo_o !== 0 || mif.busy !== 0) begin
            failures++;
            $display("FAIL abort_late hi=%h lo=%h busy=%b want 0 0 0",
                     mif.hi_o, mif.lo_o, mif.busy);
        end
    endtask

    task automatic test_back_to_back();
        run_long(MdMultu, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "b2b_multu");
        run_long(MdDivu, 32'hFFFF_FFFF, 32'd3, 1'b1, "b2b_divu");
        run_long(MdMult, 32'h8000_0000, 32'h8000_0000, 1'b0, "b2b_mult_min");
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corner [5];
        corner = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
        if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
        return $urandom();
    endfunction

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(10));
            if (is_md_long(op)) begin
                run_long(op, rand_operand(), rand_operand(), 1'($urandom_range(1)), "rand_long");
            end else begin
                // Unknown codes 9 and 10 fall in here and must behave as no-ops.
                short_op(op, rand_operand(), "rand_short");
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        proto_err = 0;
        reset     = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++;
        if (proto_err != 0) begin
            failures++;
            $display("FAIL protocol starts_while_busy=%0d want 0", proto_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
